// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V instruction fetch stage: PC, IF/ID register, redirect/stall/fault (optional FETCH_PERF_CNT_EN counters)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IMEM_PC,
    input  logic [31:0] IMEM_INST,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INST,
    output logic [31:0] IF_PC_PLUS4,
    output logic        IF_VALID,
    output logic        FETCH_FAULT
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FETCH_COUNT,
    output logic [31:0] REDIRECT_COUNT
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] if_pc_n, if_inst_n, if_pc_plus4_n;
    logic        if_valid_n, fault_n;
    logic        fetch_en, redirect_en;

    assign IMEM_PC = pc;

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        if_pc_n       = IF_PC;
        if_inst_n     = IF_INST;
        if_pc_plus4_n = IF_PC_PLUS4;
        if_valid_n    = IF_VALID;
        fault_n       = FETCH_FAULT;
        fetch_en      = 1'b0;
        redirect_en   = 1'b0;
        case (state)
            ST_BOOT: begin
                if_inst_n  = NOP_INST;
                if_valid_n = 1'b0;
                state_n    = ST_RUN;
            end
            ST_RUN: begin
                if (BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00)) begin
                    fault_n    = 1'b1;
                    if_inst_n  = NOP_INST;
                    if_valid_n = 1'b0;
                    state_n    = ST_FAULT;
                end else if (BRANCH_TAKEN) begin
                    // Redirect wins over stall; the word fetched this cycle is wrong-path.
                    pc_n        = BRANCH_TARGET;
                    if_inst_n   = NOP_INST;
                    if_valid_n  = 1'b0;
                    redirect_en = 1'b1;
                end else if (!STALL) begin
                    if_pc_n       = pc;
                    if_inst_n     = IMEM_INST;
                    if_pc_plus4_n = pc + 32'd4;
                    if_valid_n    = 1'b1;
                    pc_n          = pc + 32'd4;
                    fetch_en      = 1'b1;
                end
            end
            ST_FAULT: begin
                if_inst_n  = NOP_INST;
                if_valid_n = 1'b0;
                fault_n    = 1'b1;
            end
            default: begin
                state_n = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            IF_PC       <= 32'd0;
            IF_INST     <= NOP_INST;
            IF_PC_PLUS4 <= 32'd4;
            IF_VALID    <= 1'b0;
            FETCH_FAULT <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            IF_PC       <= if_pc_n;
            IF_INST     <= if_inst_n;
            IF_PC_PLUS4 <= if_pc_plus4_n;
            IF_VALID    <= if_valid_n;
            FETCH_FAULT <= fault_n;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            FETCH_COUNT    <= 32'd0;
            REDIRECT_COUNT <= 32'd0;
        end else begin
            if (fetch_en) begin
                FETCH_COUNT <= FETCH_COUNT + 32'd1;
            end
            if (redirect_en) begin
                REDIRECT_COUNT <= REDIRECT_COUNT + 32'd1;
            end
        end
    end
`else
    logic unused_en;
    assign unused_en = fetch_en ^ redirect_en;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_pc, imem_inst;
    logic [31:0] if_pc, if_inst, if_pc_plus4;
    logic        if_valid, fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, redirect_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory image: word n holds 0x1000_0000 + n, upper half of the address space reads 0.
    assign imem_inst = imem_pc[31] ? 32'd0 : (32'h1000_0000 + (imem_pc >> 2));

    fetch_stage dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .STALL         (stall),
        .BRANCH_TAKEN  (branch_taken),
        .BRANCH_TARGET (branch_target),
        .IMEM_PC       (imem_pc),
        .IMEM_INST     (imem_inst),
        .IF_PC         (if_pc),
        .IF_INST       (if_inst),
        .IF_PC_PLUS4   (if_pc_plus4),
        .IF_VALID      (if_valid),
        .FETCH_FAULT   (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FETCH_COUNT   (fetch_count),
        .REDIRECT_COUNT(redirect_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_inst"}, if_inst, inst);
        check({tag, "_plus4"}, if_pc_plus4, pc + 32'd4);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    endtask

    task automatic expect_bubble(input string tag, input logic [31:0] imem);
        check({tag, "_inst"}, if_inst, 32'h0000_0013);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_imem"}, imem_pc, imem);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        tick();
        tick();
        check("rst_imem", imem_pc, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_plus4", if_pc_plus4, 32'd4);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        expect_bubble("rst", 32'd0);
        rst_n = 1'b1;
        tick();
        expect_bubble("boot", 32'd0);

        tick(); expect_fetch("run0", 32'd0, 32'h1000_0000);
        tick(); expect_fetch("run1", 32'd4, 32'h1000_0001);
        tick(); expect_fetch("run2", 32'd8, 32'h1000_0002);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_fetch("stall", 32'd8, 32'h1000_0002);
            check("stall_imem", imem_pc, 32'd12);
        end
        stall = 1'b0;
        tick(); expect_fetch("unstall", 32'd12, 32'h1000_0003);

        branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
        tick();
        expect_bubble("br", 32'h40);
        check("br_hold_pc", if_pc, 32'd12);
        branch_taken = 1'b0; stall = 1'b0;
        tick(); expect_fetch("br_tgt", 32'h40, 32'h1000_0010);

        branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
        tick(); expect_bubble("wrap_br", 32'hFFFF_FFF8);
        branch_taken = 1'b0;
        tick(); expect_fetch("wrap0", 32'hFFFF_FFF8, 32'd0);
        tick(); expect_fetch("wrap1", 32'hFFFF_FFFC, 32'd0);
        check("wrap1_plus4", if_pc_plus4, 32'd0);
        tick(); expect_fetch("wrap2", 32'd0, 32'h1000_0000);

        branch_taken = 1'b1; branch_target = 32'h100;
        tick(); expect_bubble("b2b0", 32'h100);
        branch_target = 32'h200;
        tick(); expect_bubble("b2b1", 32'h200);
        branch_taken = 1'b0;
        tick(); expect_fetch("b2b_tgt", 32'h200, 32'h1000_0080);

        branch_taken = 1'b1; branch_target = 32'h42;
        tick();
        expect_bubble("flt", 32'h204);
        check("flt_flag", {31'd0, fetch_fault}, 32'd1);
        branch_target = 32'h80;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_bubble("flt_hold", 32'h204);
            check("flt_sticky", {31'd0, fetch_fault}, 32'd1);
        end
        rst_n = 1'b0;
        tick();
        check("flt_clr", {31'd0, fetch_fault}, 32'd0);
        check("flt_rst_imem", imem_pc, 32'd0);

        // Inputs asserted during BOOT must be ignored.
        rst_n = 1'b1;
        tick();
        expect_bubble("boot_ign", 32'd0);
        check("boot_ign_fault", {31'd0, fetch_fault}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("cnt_boot_f", fetch_count, 32'd0);
        check("cnt_boot_r", redirect_count, 32'd0);
`endif
        branch_taken = 1'b0;
        tick(); expect_fetch("pc0", 32'd0, 32'h1000_0000);
        tick(); expect_fetch("pc1", 32'd4, 32'h1000_0001);
        stall = 1'b1;
        tick(); expect_fetch("pc_st", 32'd4, 32'h1000_0001);
        stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
        tick(); expect_bubble("pc_br0", 32'h40);
        branch_taken = 1'b0;
        tick(); expect_fetch("pc2", 32'h40, 32'h1000_0010);
        tick(); expect_fetch("pc3", 32'h44, 32'h1000_0011);
        branch_taken = 1'b1; branch_target = 32'h80;
        tick(); expect_bubble("pc_br1", 32'h80);
        branch_taken = 1'b0;
        tick(); expect_fetch("pc4", 32'h80, 32'h1000_0020);
`ifdef FETCH_PERF_CNT_EN
        check("cnt_fetch", fetch_count, 32'd5);
        check("cnt_redir", redirect_count, 32'd2);
`endif
        rst_n = 1'b0;
        tick();
        expect_bubble("midrst", 32'd0);
        check("midrst_pc", if_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("cnt_rst_f", fetch_count, 32'd0);
        check("cnt_rst_r", redirect_count, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        tick(); expect_fetch("post", 32'd0, 32'h1000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V pipeline.
- Owns the program counter and drives the address into the combinational instruction memory (word-indexed, PC>>2; returns 0 when PC bit 31 is set).
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with squash, and a fault stop on a misaligned redirect target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, word placed in IF_INST on bubbles (addi x0,x0,0).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  synchronous active-low reset; sampled on rising CLK.
- STALL  input  1  hazard unit: hold PC and IF/ID register.
- BRANCH_TAKEN  input  1  execute stage: redirect fetch to BRANCH_TARGET.
- BRANCH_TARGET  input  32  redirect address.
- IMEM_PC  output  32  address to instruction memory; equals PC register.
- IMEM_INST  input  32  instruction word from memory, same cycle as IMEM_PC.
- IF_PC  output  32  PC of the instruction held in IF/ID.
- IF_INST  output  32  instruction held in IF/ID.
- IF_PC_PLUS4  output  32  IF_PC + 4, modulo 2^32.
- IF_VALID  output  1  IF/ID holds a real instruction.
- FETCH_FAULT  output  1  sticky: a misaligned redirect was received.

Behaviour:
- Reset (RST_N=0 at edge), overrides everything:
  - PC=RESET_PC; state=BOOT.
  - IF_PC=0, IF_INST=NOP_INST, IF_PC_PLUS4=4, IF_VALID=0, FETCH_FAULT=0.
  - Reset mid-operation discards all pending state the same edge.
- IMEM_PC is a direct copy of the PC register; no extra latency.
- States:
  - BOOT: one cycle after reset release. PC held; IF/ID loaded with bubble; next state RUN. Inputs are ignored in BOOT.
  - RUN: per edge, first matching rule applies:
    1. BRANCH_TAKEN=1 with BRANCH_TARGET[1:0]!=0 -> FETCH_FAULT=1, PC held, IF/ID bubble, next state FAULT.
    2. BRANCH_TAKEN=1 (aligned) -> PC=BRANCH_TARGET; IF/ID bubble, which squashes the wrong-path word fetched this cycle. Redirect overrides STALL.
    3. STALL=1 -> PC and all IF/ID outputs hold.
    4. Otherwise -> IF_PC=PC, IF_INST=IMEM_INST, IF_PC_PLUS4=PC+4, IF_VALID=1, PC=PC+4.
  - FAULT: PC frozen; IF/ID bubble every cycle; FETCH_FAULT stays 1. Only RST_N=0 exits.
- Bubble means IF_INST=NOP_INST, IF_VALID=0; IF_PC and IF_PC_PLUS4 hold their previous values.
- Arithmetic: 32-bit unsigned, wraps (32'hFFFF_FFFC + 4 = 0). PC values with bit 31 set are fetched normally; memory returns 0, which is passed through with IF_VALID=1. Decode handles it as an illegal instruction.
- One redirect per cycle. Back-to-back redirects on consecutive cycles each take effect; every redirect cycle produces a bubble.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs FETCH_COUNT[31:0] and REDIRECT_COUNT[31:0], both reset to 0.
  - FETCH_COUNT increments on every edge that loads IF_VALID=1 (rule 4).
  - REDIRECT_COUNT increments on every accepted aligned redirect (rule 2).
  - Both wrap at 2^32 and hold in BOOT and FAULT.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset + free run, memory word n = 0x1000_0000+n: RST_N low 2 cycles then high -> one BOOT bubble; then IF_PC = 0,4,8 with IF_INST = 0x1000_0000, 0x1000_0001, 0x1000_0002 and IF_VALID=1 on successive cycles.
- STALL high 3 cycles while IF_PC=8 -> IF_PC=8, IF_INST and IMEM_PC=12 frozen all 3 cycles; after release, next IF_PC=12.
- BRANCH_TAKEN=1, BRANCH_TARGET=0x40, with STALL=1 at the same edge -> next cycle IF_VALID=0, IF_INST=0x0000_0013, IMEM_PC=0x40; following cycle IF_PC=0x40, IF_VALID=1.
- BRANCH_TARGET=0x42 with BRANCH_TAKEN=1 -> FETCH_FAULT=1, IF_VALID=0 and IMEM_PC frozen for 10 cycles; RST_N pulse clears FETCH_FAULT and IMEM_PC=RESET_PC.
- Redirect to 0xFFFF_FFF8, run 3 cycles -> IF_PC = 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. The first two have IF_INST=0 (memory returns 0 for bit-31 addresses). IF_PC_PLUS4 at 0xFFFF_FFFC is 0.
- With FETCH_PERF_CNT_EN: 5 valid fetches, 2 redirects, 1 stall cycle -> FETCH_COUNT=5, REDIRECT_COUNT=2. A reset mid-run zeroes both counters.
